// File: rtl/prog_counter_gen.sv
// prog_counter_gen: a programmable counter that steps once per prescaled tick.
// It supports up-wrap, down-wrap, bounce and hold modes, a programmable
// inclusive limit, a synchronous load and a one-cycle terminal-count pulse.
// clock_out is the prescaled square wave, kept visible for the LEDs.
module prog_counter_gen #(
  parameter int WIDTH = 8,
  parameter int SW_W  = 4,
  parameter int DIV   = 50000000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             clock_out,
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             dir
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [PW-1:0]    r_presc;
  logic             r_clkOut;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_dir;

  mode_e            w_mode;
  logic             w_tick;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_cntWide;
  logic [WIDTH:0]   w_limWide;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_loadClamped;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextDir;
  logic             w_nextTc;

  assign w_mode        = mode_e'(mode);
  assign w_tick        = (r_presc == PRESC_MAX);
  // The step and the count are widened by one bit so an add past the
  // top of the WIDTH-bit range is still seen as exceeding the limit.
  assign w_step        = {{(WIDTH + 1 - SW_W){1'b0}}, sw_in};
  assign w_cntWide     = {1'b0, r_count};
  assign w_limWide     = {1'b0, limit};
  assign w_sum         = w_cntWide + w_step;
  assign w_diff        = r_count - w_step[WIDTH-1:0];
  assign w_loadClamped = (load_val > limit) ? limit : load_val;

  // Free-running prescaler; clock_out flips on every tick for a 2*DIV period.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_presc  <= '0;
      r_clkOut <= 1'b0;
    end else if (w_tick) begin
      r_presc  <= '0;
      r_clkOut <= ~r_clkOut;
    end else begin
      r_presc  <= r_presc + 1'b1;
    end
  end

  // Next count/direction/terminal-count for an enabled tick, by mode.
  always_comb begin
    w_nextCount = r_count;
    w_nextDir   = r_dir;
    w_nextTc    = 1'b0;
    if (en && (w_step != '0) && (w_mode != MODE_HOLD)) begin
      if (r_count > limit) begin
        // The limit was lowered under the count: restart from zero.
        w_nextCount = '0;
        w_nextDir   = 1'b1;
        w_nextTc    = 1'b1;
      end else begin
        case (w_mode)
          MODE_UP: begin
            if (w_sum > w_limWide) begin
              w_nextCount = '0;
              w_nextTc    = 1'b1;
            end else begin
              w_nextCount = w_sum[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            if (w_step > w_cntWide) begin
              w_nextCount = limit;
              w_nextTc    = 1'b1;
            end else begin
              w_nextCount = w_diff;
            end
          end
          MODE_BOUNCE: begin
            if (r_dir) begin
              if (w_sum >= w_limWide) begin
                w_nextCount = limit;
                w_nextDir   = 1'b0;
                w_nextTc    = 1'b1;
              end else begin
                w_nextCount = w_sum[WIDTH-1:0];
              end
            end else begin
              if (w_step >= w_cntWide) begin
                w_nextCount = '0;
                w_nextDir   = 1'b1;
                w_nextTc    = 1'b1;
              end else begin
                w_nextCount = w_diff;
              end
            end
          end
          default: begin
            w_nextCount = r_count;
          end
        endcase
      end
    end
  end

  // Counter state: load wins over a tick; tc is a single-cycle pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_dir   <= 1'b1;
    end else if (load) begin
      r_count <= w_loadClamped;
      r_tc    <= 1'b0;
      r_dir   <= 1'b1;
    end else if (w_tick) begin
      r_count <= w_nextCount;
      r_tc    <= w_nextTc;
      r_dir   <= w_nextDir;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign clock_out = r_clkOut;
  assign cout      = r_count;
  assign tc        = r_tc;
  assign dir       = r_dir;

endmodule

// File: tb/tb_prog_counter_gen.sv
// tb_prog_counter_gen: directed, table-driven bench for prog_counter_gen
// with DIV=4, so a tick lands on every fourth rising edge after reset.
module tb_prog_counter_gen;

  localparam int WIDTH = 8;
  localparam int SW_W  = 4;
  localparam int DIV   = 4;

  typedef struct {
    logic             en;
    logic [SW_W-1:0]  sw;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lim;
    logic             ld;
    logic [WIDTH-1:0] ldVal;
    int               nClk;
    logic [WIDTH-1:0] expCout;
    logic             expTc;
    logic             expDir;
    logic             expClk;
  } vec_t;

  logic             clock;
  logic             rst;
  logic             en;
  logic [SW_W-1:0]  swIn;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] loadVal;
  logic             clockOut;
  logic [WIDTH-1:0] cout;
  logic             tc;
  logic             dir;

  int compared;
  int mismatched;
  vec_t vecs[$];

  prog_counter_gen #(
    .WIDTH(WIDTH),
    .SW_W (SW_W),
    .DIV  (DIV)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .en       (en),
    .sw_in    (swIn),
    .mode     (mode),
    .limit    (limit),
    .load     (load),
    .load_val (loadVal),
    .clock_out(clockOut),
    .cout     (cout),
    .tc       (tc),
    .dir      (dir)
  );

  // Free-running 10-unit clock with rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic stepClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expCout,
                             input logic expTc, input logic expDir,
                             input logic expClk);
    checkOne({tag, ".cout"}, cout, expCout);
    checkOne({tag, ".tc"}, WIDTH'(tc), WIDTH'(expTc));
    checkOne({tag, ".dir"}, WIDTH'(dir), WIDTH'(expDir));
    checkOne({tag, ".clock_out"}, WIDTH'(clockOut), WIDTH'(expClk));
  endtask

  task automatic applyStimulus(input vec_t v);
    en      = v.en;
    swIn    = v.sw;
    mode    = v.mode;
    limit   = v.lim;
    load    = v.ld;
    loadVal = v.ldVal;
    stepClocks(v.nClk);
  endtask

  task automatic addVec(input logic e, input int s, input int m, input int l,
                        input logic ld, input int lv, input int n,
                        input int ec, input logic et, input logic ed,
                        input logic ek);
    vec_t v;
    v.en = e; v.sw = SW_W'(s); v.mode = 2'(m); v.lim = WIDTH'(l);
    v.ld = ld; v.ldVal = WIDTH'(lv); v.nClk = n;
    v.expCout = WIDTH'(ec); v.expTc = et; v.expDir = ed; v.expClk = ek;
    vecs.push_back(v);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    en = 1'b1; swIn = 4'd3; mode = 2'b00; limit = 8'd10;
    load = 1'b0; loadVal = 8'd0;

    // Fields: en sw mode limit load loadVal clocks | cout tc dir clock_out
    // Up-wrap by 3 to limit 10: 0,3,6,9,0 with tc on the wrap (edges 3..17).
    addVec(1, 3, 0, 10, 0, 0, 3,  0, 0, 1, 0);
    addVec(1, 3, 0, 10, 0, 0, 1,  3, 0, 1, 1);
    addVec(1, 3, 0, 10, 0, 0, 4,  6, 0, 1, 0);
    addVec(1, 3, 0, 10, 0, 0, 4,  9, 0, 1, 1);
    addVec(1, 3, 0, 10, 0, 0, 4,  0, 1, 1, 0);
    addVec(1, 3, 0, 10, 0, 0, 1,  0, 0, 1, 0);
    // Down-wrap by 4 from a load of 5: 5,1,10,6,2,10 (edges 18..36).
    addVec(1, 4, 1, 10, 1, 5, 1,  5, 0, 1, 0);
    addVec(1, 4, 1, 10, 0, 0, 2,  1, 0, 1, 1);
    addVec(1, 4, 1, 10, 0, 0, 4, 10, 1, 1, 0);
    addVec(1, 4, 1, 10, 0, 0, 4,  6, 0, 1, 1);
    addVec(1, 4, 1, 10, 0, 0, 4,  2, 0, 1, 0);
    addVec(1, 4, 1, 10, 0, 0, 4, 10, 1, 1, 1);
    // Bounce by 3 within 0..7: 0,3,6,7,4,1,0,3 (edges 37..64).
    addVec(1, 3, 2, 7, 1, 0, 1,  0, 0, 1, 1);
    addVec(1, 3, 2, 7, 0, 0, 3,  3, 0, 1, 0);
    addVec(1, 3, 2, 7, 0, 0, 4,  6, 0, 1, 1);
    addVec(1, 3, 2, 7, 0, 0, 4,  7, 1, 0, 0);
    addVec(1, 3, 2, 7, 0, 0, 4,  4, 0, 0, 1);
    addVec(1, 3, 2, 7, 0, 0, 4,  1, 0, 0, 0);
    addVec(1, 3, 2, 7, 0, 0, 4,  0, 1, 1, 1);
    addVec(1, 3, 2, 7, 0, 0, 4,  3, 0, 1, 0);
    // Load on a tick cycle clamps to the limit and skips the step (edge 68).
    addVec(1, 3, 0, 100, 0, 0, 3,    3, 0, 1, 0);
    addVec(1, 3, 0, 100, 1, 200, 1, 100, 0, 1, 1);
    addVec(1, 3, 0, 100, 0, 0, 4,    0, 1, 1, 0);
    // Limit dropped under a count of 9: en=0 holds, step 0 holds, then reset to 0.
    addVec(1, 3, 0, 10, 1, 9, 1,  9, 0, 1, 0);
    addVec(0, 3, 0, 5, 0, 0, 3,   9, 0, 1, 1);
    addVec(1, 0, 0, 5, 0, 0, 4,   9, 0, 1, 0);
    addVec(1, 3, 0, 5, 0, 0, 4,   0, 1, 1, 1);
    addVec(1, 3, 0, 5, 0, 0, 1,   0, 0, 1, 1);
    // Limit of zero: every enabled tick pulses tc; bounce flips dir each time.
    addVec(1, 1, 1, 0, 0, 0, 3,   0, 1, 1, 0);
    addVec(1, 1, 2, 0, 0, 0, 4,   0, 1, 0, 1);
    addVec(1, 1, 2, 0, 0, 0, 4,   0, 1, 1, 0);

    // Reset is asserted with an explicit falling edge before the first clock.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 checkOutput("reset", 8'd0, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCout, vecs[i].expTc,
                  vecs[i].expDir, vecs[i].expClk);
    end

    // Mid-count asynchronous reset, then the first tick DIV edges after release.
    begin
      vec_t v;
      v.en = 1'b1; v.sw = 4'd5; v.mode = 2'b00; v.lim = 8'd100;
      v.ld = 1'b1; v.ldVal = 8'd50; v.nClk = 1;
      applyStimulus(v);
      checkOutput("preRstLoad", 8'd50, 1'b0, 1'b1, 1'b0);
      v.ld = 1'b0; v.nClk = 3;
      applyStimulus(v);
      checkOutput("preRstTick", 8'd55, 1'b0, 1'b1, 1'b1);
    end
    #3 rst = 1'b0;
    #1 checkOutput("asyncRst", 8'd0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    stepClocks(DIV - 1);
    checkOutput("postRstNoTick", 8'd0, 1'b0, 1'b1, 1'b0);
    stepClocks(1);
    checkOutput("postRstTick", 8'd5, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_counter_gen.md
Name: prog_counter_gen

Overview:
- Parametrised successor to the board's programmable counter.
- A prescaler divides the system clock down to a count tick.
- On each tick, a WIDTH-bit counter steps by a switch-programmed amount, in one of four modes: up-wrap, down-wrap, up/down bounce, hold.
- The counter has a programmable limit, a synchronous load and a terminal-count pulse.
- It sits between the board switches/buttons and the LED / 7-seg display drivers. clock_out remains as a visible square wave for the LEDs.

Parameters:
- WIDTH, 8, counter and limit width in bits.
- SW_W, 4, step-input width in bits (SW_W <= WIDTH).
- DIV, 50000000, prescaler ratio: one count tick every DIV clock cycles (DIV >= 2).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable, sampled only on tick cycles.
- sw_in  in  SW_W  step size, unsigned. 0 means the counter holds.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- limit  in  WIDTH  inclusive upper bound of the count range.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- clock_out  out  1  prescaled square wave; toggles on every tick.
- cout  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse.
- dir  out  1  current direction in bounce mode (1 up, 0 down).

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, clock_out=0, cout=0, tc=0, dir=1. Reset applied mid-count aborts all state immediately. The first tick after release occurs on the DIV-th rising edge.
- Prescaler: counts 0..DIV-1 freely, independent of en and mode.
  - The internal tick is high for the one cycle where the prescaler equals DIV-1, and the prescaler then wraps to 0.
  - clock_out toggles on each tick, giving period 2*DIV.
- Priority per cycle: load > tick.
- Load:
  - cout <= min(load_val, limit), dir <= 1, tc <= 0.
  - Load acts regardless of en and tick, does not disturb the prescaler, and takes effect on the next edge.
- Tick-gating: on a tick with en=1, the counter updates according to mode. Otherwise cout is unchanged.
- Step arithmetic: computed at WIDTH+1 bits, with sw_in zero-extended, so no silent overflow.
- Out-of-range precheck: if cout > limit at a tick (limit lowered at runtime), then cout <= 0, dir <= 1, tc pulses, and the mode rule is skipped for that tick.
- Mode 00, up-wrap:
  - If cout+step > limit: cout <= 0, tc=1.
  - Otherwise: cout <= cout+step.
- Mode 01, down-wrap:
  - If step > cout: cout <= limit, tc=1.
  - Otherwise: cout <= cout-step.
- Mode 10, bounce:
  - dir=1: if cout+step >= limit, then cout <= limit, dir <= 0, tc=1; otherwise add.
  - dir=0: if step >= cout, then cout <= 0, dir <= 1, tc=1; otherwise subtract.
  - Endpoints are always hit exactly.
- Mode 11, hold: no change, tc=0.
- Mode changes take effect at the next tick. dir is retained when leaving and re-entering bounce.
- Step 0: no change and no tc in every mode.
- limit=0: counter stays 0, and tc pulses on every enabled up/down/bounce tick with step >= 1.
- tc: registered, high exactly one cycle (the cycle after the tick edge), 0 at all other times.
- Latency: cout updates one clock after the tick cycle. dir and tc update in the same edge as cout.

Test Plan:
- DIV=4, WIDTH=8, mode=00, sw_in=3, limit=10, en=1, release rst -> cout 0,3,6,9,0 on successive ticks every 4 clocks. tc pulses once at the 9->0 wrap. clock_out period = 8 clocks.
- mode=01, sw_in=4, limit=10, load load_val=5 -> cout 5,1,10,6,2,10. tc on each jump to 10.
- mode=10, sw_in=3, limit=7, start 0 -> cout 3,6,7,4,1,0,3. dir flips at 7 and 0, and tc pulses at each.
- Load versus tick: assert load with load_val=200, limit=100 on a tick cycle -> cout=100, no step applied, tc=0, prescaler phase unchanged.
- Runtime limit drop: cout=9, set limit=5, mode=00 -> next tick cout=0 with tc. With en=0 instead, cout holds 9 with no tc. With sw_in=0, no change.
- Pull rst low between ticks mid-count -> cout, tc, clock_out go 0 and dir goes 1 immediately, without waiting for a clock edge. After release, the first tick arrives DIV clocks later.
